// File: rtl/rb_write_scheduler.sv
// rb_write_scheduler: orders writeback FIFO writes and pointer-register flush sweeps onto the single RB write port
module rb_write_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int RB_ENTRIES = 16,
  parameter int DATA_W     = 32
) (
  input  logic                          ClockIn,
  input  logic                          ResetIn,
  input  logic                          WbWrEnIn,
  input  logic                          WbWrValidIn,
  input  logic [$clog2(RB_ENTRIES)-1:0] WbWrIdxIn,
  input  logic [1:0]                    WbPtrRegIdIn,
  input  logic [DATA_W-1:0]             WbWrDataIn,
  output logic                          WbReadyOut,
  output logic                          StallOut,
  input  logic                          FlushReqIn,
  input  logic [1:0]                    FlushPtrRegIdIn,
  output logic                          FlushBusyOut,
  output logic                          FlushAckOut,
  output logic                          RbWrEnOut,
  input  logic                          RbPortReadyIn,
  output logic                          RbWrValidOut,
  output logic [$clog2(RB_ENTRIES)-1:0] RbWrIdxOut,
  output logic [1:0]                    RbPtrRegIdOut,
  output logic [DATA_W-1:0]             RbWrDataOut
);
  localparam int IW = $clog2(RB_ENTRIES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + IW + 2 + DATA_W;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, nxt_ptr;
  logic [CW-1:0] count_q, count_d, avail, drain_q, drain_d;
  state_t        state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d;
  logic [1:0]    flush_id_q, flush_id_d;
  logic          ack_q, ack_d;
  logic          rb_en_q, rb_en_d;
  logic [EW-1:0] rb_q, rb_d;
  logic          enq, hs, deq, free, fifo_ok;
  // The presented FIFO write stays at the head until its handshake, so count includes it
  assign WbReadyOut    = !ResetIn && (count_q != CW'(FIFO_DEPTH));
  assign StallOut      = WbWrEnIn & ~WbReadyOut;
  assign enq           = WbWrEnIn & WbReadyOut;
  assign hs            = rb_en_q & RbPortReadyIn;
  assign deq           = hs & (state_q != FLUSH);
  assign avail         = count_q - CW'(deq);
  assign nxt_ptr       = rd_ptr_q + PW'(deq);
  assign free          = !rb_en_q | hs;
  assign count_d       = count_q + CW'(enq) - CW'(deq);
  assign RbWrEnOut     = rb_en_q;
  assign {RbWrValidOut, RbWrIdxOut, RbPtrRegIdOut, RbWrDataOut} = rb_q;
  assign FlushBusyOut  = state_q != IDLE;
  assign FlushAckOut   = ack_q;
  // Next state: flush sampled only in IDLE; drain the entries queued before it, then sweep every index
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    sweep_d    = sweep_q;
    flush_id_d = flush_id_q;
    ack_d      = 1'b0;
    case (state_q)
      IDLE: if (FlushReqIn) begin
        flush_id_d = FlushPtrRegIdIn;
        drain_d    = avail;
        sweep_d    = '0;
        state_d    = (avail != '0) ? DRAIN : FLUSH;
      end
      DRAIN: if (hs) begin
        drain_d = drain_q - CW'(1);
        state_d = (drain_d == '0) ? FLUSH : DRAIN;
      end
      FLUSH: if (hs) begin
        sweep_d = sweep_q + IW'(1);
        state_d = (sweep_q == IW'(RB_ENTRIES - 1)) ? IDLE : FLUSH;
        ack_d   = sweep_q == IW'(RB_ENTRIES - 1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Output register: load an invalidate on entering/advancing the sweep, else the next eligible FIFO entry
  always_comb begin
    rb_en_d = rb_en_q;
    rb_d    = rb_q;
    fifo_ok = (state_q == IDLE) ? (avail != '0) : (drain_d != '0);
    if (state_d == FLUSH && (state_q != FLUSH || hs)) begin
      rb_en_d = 1'b1;
      rb_d    = {1'b0, sweep_d, flush_id_d, {DATA_W{1'b0}}};
    end else if (state_q == FLUSH) begin
      rb_en_d = rb_en_q & ~hs;
    end else if (free) begin
      rb_en_d = fifo_ok;
      rb_d    = fifo_ok ? mem_q[nxt_ptr] : rb_q;
    end
  end
  // FIFO storage needs no reset; only accepted writes land
  always_ff @(posedge ClockIn)
    if (enq) mem_q[wr_ptr_q] <= {WbWrValidIn, WbWrIdxIn, WbPtrRegIdIn, WbWrDataIn};
  // State register; reset aborts any flush silently
  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      drain_q    <= '0;
      sweep_q    <= '0;
      flush_id_q <= '0;
      ack_q      <= 1'b0;
      rb_en_q    <= 1'b0;
      rb_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PW'(enq);
      rd_ptr_q   <= nxt_ptr;
      count_q    <= count_d;
      state_q    <= state_d;
      drain_q    <= drain_d;
      sweep_q    <= sweep_d;
      flush_id_q <= flush_id_d;
      ack_q      <= ack_d;
      rb_en_q    <= rb_en_d;
      rb_q       <= rb_d;
    end
  end
endmodule

// File: tb/tb_rb_write_scheduler.sv
// tb_rb_write_scheduler: directed checks of write ordering, backpressure, flush sweep and reset abort
module tb_rb_write_scheduler;
  logic        clk = 1'b0;
  logic        rst, wb_en, wb_valid, flush_req, rdy;
  logic [3:0]  wb_idx;
  logic [1:0]  wb_ptr, flush_id;
  logic [31:0] wb_data;
  logic        wb_ready, stall, busy, ack, rb_en, rb_valid;
  logic [3:0]  rb_idx;
  logic [1:0]  rb_ptr;
  logic [31:0] rb_data;
  int checks = 0, errors = 0, acks = 0, ack_at = -1, overlap = 0;
  logic [38:0] log_q[$];

  rb_write_scheduler dut (
    .ClockIn(clk), .ResetIn(rst),
    .WbWrEnIn(wb_en), .WbWrValidIn(wb_valid), .WbWrIdxIn(wb_idx), .WbPtrRegIdIn(wb_ptr),
    .WbWrDataIn(wb_data), .WbReadyOut(wb_ready), .StallOut(stall),
    .FlushReqIn(flush_req), .FlushPtrRegIdIn(flush_id), .FlushBusyOut(busy), .FlushAckOut(ack),
    .RbWrEnOut(rb_en), .RbPortReadyIn(rdy), .RbWrValidOut(rb_valid), .RbWrIdxOut(rb_idx),
    .RbPtrRegIdOut(rb_ptr), .RbWrDataOut(rb_data)
  );

  always #5 clk = ~clk;

  // Mid-cycle observer: records every RB handshake and every ack
  always @(negedge clk)
    if (!rst) begin
      if (ack) begin
        acks++;
        ack_at = log_q.size();
      end
      if (ack && busy) overlap++;
      if (rb_en && rdy) log_q.push_back({rb_valid, rb_idx, rb_ptr, rb_data});
    end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic e, input logic [3:0] i, input logic [31:0] d);
    wb_en = e; wb_idx = i; wb_data = d; wb_valid = 1'b1; wb_ptr = 2'd1;
  endtask

  task automatic chk_rb(input string tag, input logic [3:0] i, input logic [31:0] d);
    chk({tag, "_en"}, 64'(rb_en), 64'd1);
    chk({tag, "_idx"}, 64'(rb_idx), 64'(i));
    chk({tag, "_data"}, 64'(rb_data), 64'(d));
  endtask

  function automatic logic [38:0] ent(input logic v, input logic [3:0] i, input logic [1:0] p,
                                      input logic [31:0] d);
    return {v, i, p, d};
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b0; flush_req = 1'b0; flush_id = 2'd0;
    wb(1'b0, 4'd0, 32'd0);
    tick(); tick();
    chk("rst_ready", 64'(wb_ready), 64'd0);
    chk("rst_en", 64'(rb_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    rst = 1'b0; rdy = 1'b1;
    #1 chk("ready_after_rst", 64'(wb_ready), 64'd1);
    // three in-order writes
    wb(1'b1, 4'd1, 32'hA); tick();
    chk("first_latency", 64'(rb_en), 64'd0);
    wb(1'b1, 4'd2, 32'hB); tick();
    chk_rb("wr1", 4'd1, 32'hA);
    wb(1'b1, 4'd3, 32'hC); tick();
    chk_rb("wr2", 4'd2, 32'hB);
    wb(1'b0, 4'd0, 32'd0); tick();
    chk_rb("wr3", 4'd3, 32'hC);
    tick();
    chk("idle_after3", 64'(rb_en), 64'd0);
    // backpressure: fill the FIFO, fifth attempt stalls
    rdy = 1'b0; log_q.delete();
    for (int i = 0; i < 5; i++) begin
      wb(1'b1, 4'(4 + i), 32'(16 + i));
      #1;
      chk($sformatf("fill_ready%0d", i), 64'(wb_ready), 64'(i < 4));
      chk($sformatf("fill_stall%0d", i), 64'(stall), 64'(i == 4));
      tick();
    end
    chk_rb("held_a", 4'd4, 32'h10);
    tick();
    chk_rb("held_b", 4'd4, 32'h10);
    chk("held_stall", 64'(stall), 64'd1);
    rdy = 1'b1; tick();
    chk_rb("resume", 4'd5, 32'h11);
    chk("resume_ready", 64'(wb_ready), 64'd1);
    chk("resume_stall", 64'(stall), 64'd0);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    repeat (6) tick();
    chk("bp_count", 64'(log_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_log%0d", i), 64'(log_q[i]), 64'(ent(1'b1, 4'(4 + i), 2'd1, 32'(16 + i))));
    // flush after two queued writes, one more write queued behind the flush
    rdy = 1'b0; log_q.delete(); acks = 0;
    wb(1'b1, 4'd9, 32'h21); tick();
    wb(1'b1, 4'd10, 32'h22); tick();
    wb(1'b0, 4'd0, 32'd0); flush_req = 1'b1; flush_id = 2'd2; tick();
    flush_req = 1'b0; wb(1'b1, 4'd11, 32'h23);
    chk("drain_busy", 64'(busy), 64'd1);
    tick();
    wb(1'b0, 4'd0, 32'd0); rdy = 1'b1;
    for (int c = 0; c < 40 && acks == 0; c++) tick();
    repeat (4) tick();
    chk("fl_count", 64'(log_q.size()), 64'd19);
    chk("fl_old0", 64'(log_q[0]), 64'(ent(1'b1, 4'd9, 2'd1, 32'h21)));
    chk("fl_old1", 64'(log_q[1]), 64'(ent(1'b1, 4'd10, 2'd1, 32'h22)));
    for (int i = 0; i < 16; i++)
      chk($sformatf("fl_inv%0d", i), 64'(log_q[2 + i]), 64'(ent(1'b0, 4'(i), 2'd2, 32'd0)));
    chk("fl_new", 64'(log_q[18]), 64'(ent(1'b1, 4'd11, 2'd1, 32'h23)));
    chk("fl_acks", 64'(acks), 64'd1);
    chk("fl_ack_pos", 64'(ack_at), 64'd18);
    // empty-FIFO flush with toggling ready and an ignored second request
    log_q.delete(); acks = 0; rdy = 1'b0;
    flush_req = 1'b1; flush_id = 2'd3; tick();
    flush_req = 1'b0;
    chk("tg_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 80 && acks == 0; c++) begin
      rdy = c[0];
      flush_req = (c == 4); flush_id = 2'd1;
      tick();
    end
    flush_req = 1'b0; rdy = 1'b1;
    repeat (5) tick();
    chk("tg_count", 64'(log_q.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("tg_inv%0d", i), 64'(log_q[i]), 64'(ent(1'b0, 4'(i), 2'd3, 32'd0)));
    chk("tg_acks", 64'(acks), 64'd1);
    chk("tg_ack_pos", 64'(ack_at), 64'd16);
    chk("tg_busy_end", 64'(busy), 64'd0);
    // reset mid-sweep
    log_q.delete(); acks = 0;
    flush_req = 1'b1; flush_id = 2'd1; tick();
    flush_req = 1'b0;
    for (int c = 0; c < 40 && log_q.size() < 8; c++) tick();
    rst = 1'b1; rdy = 1'b0; tick();
    chk("ab_en", 64'(rb_en), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_ack", 64'(ack), 64'd0);
    chk("ab_ready_in_rst", 64'(wb_ready), 64'd0);
    tick();
    rst = 1'b0; rdy = 1'b1;
    #1 chk("ab_ready", 64'(wb_ready), 64'd1);
    repeat (20) tick();
    chk("ab_count", 64'(log_q.size()), 64'd8);
    chk("ab_last", 64'(log_q[7]), 64'(ent(1'b0, 4'd7, 2'd1, 32'd0)));
    chk("ab_acks", 64'(acks), 64'd0);
    chk("ab_idle_en", 64'(rb_en), 64'd0);
    chk("ack_busy_exclusive", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
